// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, requester ids
// and the byte-to-word address helper used by the hazard comparator.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic PORT_IC = 1'b0;
  localparam logic PORT_DC = 1'b1;

  // Word address of a byte address (drops the two byte-lane bits).
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Write-through byte buffer: circular storage with a count, full/empty flags
// and a parallel word-address match against a query address that also covers
// the entry being pushed in the current cycle.
module wbuf_fifo
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [7:0]        i_push_data,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_query_addr,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [7:0]        o_head_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_match
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [7:0]        r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DEPTH-1:0]  w_hit;
  logic              w_push_hit;

  // Entry storage; contents need no reset because r_valid qualifies them.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers, count and per-slot valid bits. When full, push and pop hit the
  // same slot; the push is applied last so the slot stays valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (i_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      if (i_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // One word-address comparator per slot.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign w_hit[gi] = r_valid[gi] &&
                         (word_addr(32'(r_addr[gi])) == word_addr(32'(i_query_addr)));
    end
  endgenerate

  assign w_push_hit  = i_push && (word_addr(32'(i_push_addr)) == word_addr(32'(i_query_addr)));
  assign o_match     = (|w_hit) || w_push_hit;
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache refills and dcache refills plus
// buffered write-through bytes, keeping reads behind older writes to the
// same word.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_rreq,
  input  logic [ADDR_W-1:0] ic_raddr,
  output logic [31:0]       ic_rdata,
  output logic              ic_rvalid,
  input  logic              dc_rreq,
  input  logic [ADDR_W-1:0] dc_raddr,
  output logic [31:0]       dc_rdata,
  output logic              dc_rvalid,
  input  logic              dc_wreq,
  input  logic [ADDR_W-1:0] dc_waddr,
  input  logic [7:0]        dc_wdata,
  output logic              wbuf_full,
  output logic              wbuf_overflow,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  input  logic              mem_wack
);

  state_t            r_state, w_state_next;
  logic              r_mem_req, w_mem_req_next;
  logic              r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [7:0]        r_mem_wdata, w_mem_wdata_next;
  logic [31:0]       r_ic_rdata, w_ic_rdata_next;
  logic [31:0]       r_dc_rdata, w_dc_rdata_next;
  logic              r_ic_rvalid, w_ic_rvalid_next;
  logic              r_dc_rvalid, w_dc_rvalid_next;
  logic              r_rr_last, w_rr_last_next;
  logic              r_grant, w_grant_next;
  logic              r_overflow;

  logic              w_ic_cand, w_dc_cand, w_cand_valid, w_cand_port;
  logic [ADDR_W-1:0] w_cand_addr, w_head_addr, w_issue_addr;
  logic [7:0]        w_head_data, w_issue_data;
  logic              w_push, w_pop, w_full, w_empty, w_match;

  // A requester whose rvalid is pulsing still holds rreq high; mask it.
  assign w_ic_cand    = ic_rreq && !r_ic_rvalid;
  assign w_dc_cand    = dc_rreq && !r_dc_rvalid;
  assign w_cand_valid = w_ic_cand || w_dc_cand;
  assign w_cand_port  = (w_ic_cand && w_dc_cand) ? ~r_rr_last :
                        (w_dc_cand ? PORT_DC : PORT_IC);
  assign w_cand_addr  = (w_cand_port == PORT_DC) ? dc_raddr : ic_raddr;

  // Popping in the same cycle frees the slot, so a push is still taken when full.
  assign w_push = dc_wreq && (!w_full || w_pop);

  // A write forced by a same-cycle push into an empty buffer must issue that push.
  assign w_issue_addr = w_empty ? dc_waddr : w_head_addr;
  assign w_issue_data = w_empty ? dc_wdata : w_head_data;

  wbuf_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_addr  (dc_waddr),
    .i_push_data  (dc_wdata),
    .i_pop        (w_pop),
    .i_query_addr (w_cand_addr),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_match      (w_match)
  );

  // Next-state and registered-output decisions; writes win on full buffer or hazard.
  always_comb begin
    w_state_next     = r_state;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_ic_rdata_next  = r_ic_rdata;
    w_dc_rdata_next  = r_dc_rdata;
    w_ic_rvalid_next = 1'b0;
    w_dc_rvalid_next = 1'b0;
    w_rr_last_next   = r_rr_last;
    w_grant_next     = r_grant;
    w_pop            = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_full || (w_cand_valid && w_match) || (!w_cand_valid && !w_empty)) begin
          w_state_next     = WRITE;
          w_mem_req_next   = 1'b1;
          w_mem_we_next    = 1'b1;
          w_mem_addr_next  = w_issue_addr;
          w_mem_wdata_next = w_issue_data;
        end else if (w_cand_valid) begin
          w_state_next    = READ;
          w_mem_req_next  = 1'b1;
          w_mem_we_next   = 1'b0;
          w_mem_addr_next = w_cand_addr;
          w_rr_last_next  = w_cand_port;
          w_grant_next    = w_cand_port;
        end
      end
      READ: begin
        if (mem_rvalid) begin
          if (r_grant == PORT_IC) begin
            w_ic_rdata_next  = mem_rdata;
            w_ic_rvalid_next = 1'b1;
          end else begin
            w_dc_rdata_next  = mem_rdata;
            w_dc_rvalid_next = 1'b1;
          end
          w_mem_req_next = 1'b0;
          w_state_next   = IDLE;
        end
      end
      WRITE: begin
        if (mem_wack) begin
          w_pop          = 1'b1;
          w_mem_req_next = 1'b0;
          w_mem_we_next  = 1'b0;
          w_state_next   = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ic_rdata  <= '0;
      r_dc_rdata  <= '0;
      r_ic_rvalid <= 1'b0;
      r_dc_rvalid <= 1'b0;
      r_rr_last   <= PORT_IC;
      r_grant     <= PORT_IC;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_ic_rdata  <= w_ic_rdata_next;
      r_dc_rdata  <= w_dc_rdata_next;
      r_ic_rvalid <= w_ic_rvalid_next;
      r_dc_rvalid <= w_dc_rvalid_next;
      r_rr_last   <= w_rr_last_next;
      r_grant     <= w_grant_next;
      r_overflow  <= r_overflow | (dc_wreq && w_full && !w_pop);
    end
  end

  assign ic_rdata      = r_ic_rdata;
  assign ic_rvalid     = r_ic_rvalid;
  assign dc_rdata      = r_dc_rdata;
  assign dc_rvalid     = r_dc_rvalid;
  assign wbuf_full     = w_full;
  assign wbuf_overflow = r_overflow;
  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both caches and the
// memory, and compares every observation against hand-computed values.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ic_rreq = 1'b0, dc_rreq = 1'b0, dc_wreq = 1'b0;
  logic [12:0] ic_raddr = '0, dc_raddr = '0, dc_waddr = '0;
  logic [7:0]  dc_wdata = '0;
  logic [31:0] ic_rdata, dc_rdata;
  logic        ic_rvalid, dc_rvalid, wbuf_full, wbuf_overflow;
  logic        mem_req, mem_we;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0, mem_wack = 1'b0;

  int checks = 0;
  int errors = 0;

  logic        t_we;
  logic [12:0] t_addr;
  logic [7:0]  t_wd;

  mem_port_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .ic_rreq       (ic_rreq),
    .ic_raddr      (ic_raddr),
    .ic_rdata      (ic_rdata),
    .ic_rvalid     (ic_rvalid),
    .dc_rreq       (dc_rreq),
    .dc_raddr      (dc_raddr),
    .dc_rdata      (dc_rdata),
    .dc_rvalid     (dc_rvalid),
    .dc_wreq       (dc_wreq),
    .dc_waddr      (dc_waddr),
    .dc_wdata      (dc_wdata),
    .wbuf_full     (wbuf_full),
    .wbuf_overflow (wbuf_overflow),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .mem_wack      (mem_wack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a memory request, hold it one cycle, then answer it.
  task automatic serve(input logic [31:0] rd, output logic we, output logic [12:0] addr,
                       output logic [7:0] wd);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("mem_req_seen", 32'(mem_req), 32'd1);
    we   = mem_we;
    addr = mem_addr;
    wd   = mem_wdata;
    tick();
    if (we) mem_wack = 1'b1;
    else begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
    end
    tick();
    mem_wack   = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic push(input logic [12:0] a, input logic [7:0] d);
    dc_wreq  = 1'b1;
    dc_waddr = a;
    dc_wdata = d;
    tick();
    dc_wreq  = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ic_rvalid", 32'(ic_rvalid), 32'd0);
    chk("rst_dc_rvalid", 32'(dc_rvalid), 32'd0);
    chk("rst_full", 32'(wbuf_full), 32'd0);
    chk("rst_ovf", 32'(wbuf_overflow), 32'd0);

    // Single icache read, memory answers two cycles after mem_req
    ic_rreq = 1'b1; ic_raddr = 13'h0100;
    tick();
    chk("r1_req", 32'(mem_req), 32'd1);
    chk("r1_we", 32'(mem_we), 32'd0);
    chk("r1_addr", 32'(mem_addr), 32'h0100);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("r1_ic_rvalid", 32'(ic_rvalid), 32'd1);
    chk("r1_ic_rdata", ic_rdata, 32'hDEADBEEF);
    chk("r1_req_drop", 32'(mem_req), 32'd0);
    tick();
    chk("r1_pulse_end", 32'(ic_rvalid), 32'd0);
    chk("r1_no_dup", 32'(mem_req), 32'd0);
    ic_rreq = 1'b0;
    tick();
    chk("r1_idle", 32'(mem_req), 32'd0);

    // Simultaneous requests with rr_last = IC: dc first, then ic
    ic_rreq = 1'b1; ic_raddr = 13'h0200;
    dc_rreq = 1'b1; dc_raddr = 13'h0300;
    serve(32'hD0D00001, t_we, t_addr, t_wd);
    chk("rr1_addr", 32'(t_addr), 32'h0300);
    chk("rr1_dc_rvalid", 32'(dc_rvalid), 32'd1);
    chk("rr1_dc_rdata", dc_rdata, 32'hD0D00001);
    chk("rr1_ic_rvalid", 32'(ic_rvalid), 32'd0);
    dc_rreq = 1'b0;
    serve(32'h1C1C0002, t_we, t_addr, t_wd);
    chk("rr2_addr", 32'(t_addr), 32'h0200);
    chk("rr2_ic_rvalid", 32'(ic_rvalid), 32'd1);
    chk("rr2_ic_rdata", ic_rdata, 32'h1C1C0002);
    ic_rreq = 1'b0;
    // dc alone leaves rr_last = DC, so the next tie goes to ic
    dc_rreq = 1'b1; dc_raddr = 13'h0304;
    serve(32'h00000003, t_we, t_addr, t_wd);
    chk("rr3_addr", 32'(t_addr), 32'h0304);
    dc_rreq = 1'b0;
    ic_rreq = 1'b1; ic_raddr = 13'h0204;
    dc_rreq = 1'b1; dc_raddr = 13'h0308;
    serve(32'h00000004, t_we, t_addr, t_wd);
    chk("rr4_addr_ic", 32'(t_addr), 32'h0204);
    chk("rr4_ic_rvalid", 32'(ic_rvalid), 32'd1);
    ic_rreq = 1'b0;
    serve(32'h00000005, t_we, t_addr, t_wd);
    chk("rr5_addr_dc", 32'(t_addr), 32'h0308);
    chk("rr5_dc_rvalid", 32'(dc_rvalid), 32'd1);
    dc_rreq = 1'b0;

    // Read-after-write hazard: three writes drain before the read of the same word
    push(13'h0040, 8'h11);
    push(13'h0041, 8'h22);
    push(13'h0042, 8'h33);
    dc_rreq = 1'b1; dc_raddr = 13'h0043;
    serve(32'h0, t_we, t_addr, t_wd);
    chk("haz_w0", {t_we, 10'd0, t_addr, t_wd}, {1'b1, 10'd0, 13'h0040, 8'h11});
    serve(32'h0, t_we, t_addr, t_wd);
    chk("haz_w1", {t_we, 10'd0, t_addr, t_wd}, {1'b1, 10'd0, 13'h0041, 8'h22});
    serve(32'h0, t_we, t_addr, t_wd);
    chk("haz_w2", {t_we, 10'd0, t_addr, t_wd}, {1'b1, 10'd0, 13'h0042, 8'h33});
    serve(32'h44332211, t_we, t_addr, t_wd);
    chk("haz_rd_we", 32'(t_we), 32'd0);
    chk("haz_rd_addr", 32'(t_addr), 32'h0043);
    chk("haz_dc_rdata", dc_rdata, 32'h44332211);
    dc_rreq = 1'b0;

    // Unrelated writes pending: the read overtakes them
    ic_rreq = 1'b1; ic_raddr = 13'h0100;
    push(13'h0800, 8'h80);
    push(13'h0801, 8'h81);
    serve(32'hCAFE0000, t_we, t_addr, t_wd);
    chk("byp_rd", {t_we, 18'd0, t_addr}, {1'b0, 18'd0, 13'h0100});
    chk("byp_ic_rvalid", 32'(ic_rvalid), 32'd1);
    ic_rreq = 1'b0;
    serve(32'h0, t_we, t_addr, t_wd);
    chk("byp_w0", {t_we, 10'd0, t_addr, t_wd}, {1'b1, 10'd0, 13'h0800, 8'h80});
    serve(32'h0, t_we, t_addr, t_wd);
    chk("byp_w1", {t_we, 10'd0, t_addr, t_wd}, {1'b1, 10'd0, 13'h0801, 8'h81});

    // Same-cycle push into an empty buffer hazards the read
    dc_rreq = 1'b1; dc_raddr = 13'h0050;
    push(13'h0051, 8'h5A);
    serve(32'h0, t_we, t_addr, t_wd);
    chk("scp_w", {t_we, 10'd0, t_addr, t_wd}, {1'b1, 10'd0, 13'h0051, 8'h5A});
    serve(32'h00005A00, t_we, t_addr, t_wd);
    chk("scp_rd", {t_we, 18'd0, t_addr}, {1'b0, 18'd0, 13'h0050});
    chk("scp_dc_rdata", dc_rdata, 32'h00005A00);
    dc_rreq = 1'b0;

    // Fill with mem_wack low, push+pop while full, then overflow
    push(13'h0010, 8'hA0);
    push(13'h0011, 8'hA1);
    push(13'h0012, 8'hA2);
    push(13'h0013, 8'hA3);
    chk("fill_full", 32'(wbuf_full), 32'd1);
    chk("fill_ovf", 32'(wbuf_overflow), 32'd0);
    chk("fill_head", {mem_req, mem_we, 9'd0, mem_addr, mem_wdata}, {2'b11, 9'd0, 13'h0010, 8'hA0});
    dc_wreq = 1'b1; dc_waddr = 13'h0015; dc_wdata = 8'hB5; mem_wack = 1'b1;
    tick();
    dc_wreq = 1'b0; mem_wack = 1'b0;
    chk("pp_full", 32'(wbuf_full), 32'd1);
    chk("pp_ovf", 32'(wbuf_overflow), 32'd0);
    push(13'h0016, 8'hDD);
    chk("ovf_set", 32'(wbuf_overflow), 32'd1);
    chk("ovf_full", 32'(wbuf_full), 32'd1);
    serve(32'h0, t_we, t_addr, t_wd);
    chk("dr_w0", {t_we, 10'd0, t_addr, t_wd}, {1'b1, 10'd0, 13'h0011, 8'hA1});
    serve(32'h0, t_we, t_addr, t_wd);
    chk("dr_w1", {t_we, 10'd0, t_addr, t_wd}, {1'b1, 10'd0, 13'h0012, 8'hA2});
    serve(32'h0, t_we, t_addr, t_wd);
    chk("dr_w2", {t_we, 10'd0, t_addr, t_wd}, {1'b1, 10'd0, 13'h0013, 8'hA3});
    serve(32'h0, t_we, t_addr, t_wd);
    chk("dr_w3", {t_we, 10'd0, t_addr, t_wd}, {1'b1, 10'd0, 13'h0015, 8'hB5});
    chk("dr_not_full", 32'(wbuf_full), 32'd0);
    repeat (5) tick();
    chk("dr_no_drop_byte", 32'(mem_req), 32'd0);
    chk("dr_ovf_sticky", 32'(wbuf_overflow), 32'd1);

    // Asynchronous reset in the middle of a read with a full buffer
    ic_rreq = 1'b1; ic_raddr = 13'h0180;
    tick();
    chk("ar_req", 32'(mem_req), 32'd1);
    push(13'h0020, 8'h01);
    push(13'h0024, 8'h02);
    push(13'h0028, 8'h03);
    push(13'h002C, 8'h04);
    chk("ar_full", 32'(wbuf_full), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_req_drop", 32'(mem_req), 32'd0);
    chk("ar_full_drop", 32'(wbuf_full), 32'd0);
    chk("ar_ovf_clear", 32'(wbuf_overflow), 32'd0);
    chk("ar_ic_rvalid", 32'(ic_rvalid), 32'd0);
    ic_rreq = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    mem_rvalid = 1'b0;
    chk("ar_late_ic_rvalid", 32'(ic_rvalid), 32'd0);
    chk("ar_late_dc_rvalid", 32'(dc_rvalid), 32'd0);
    chk("ar_late_req", 32'(mem_req), 32'd0);
    tick();
    chk("ar_idle_rvalid", 32'(ic_rvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
